spike_event_serializer_98bit: RTL and testbench
===============================================

# spike_event_serializer_98bit

Converts a 98-bit per-timestep spike vector into a stream of 7-bit neuron-index events, one per handshake, in ascending index order. Sits directly downstream of the neuron array's spike-vector output, uses the 98-bit priority encoding to find the next pending spike, and feeds the address-event consumer (synapse fetch / output FIFO). Also reports a per-frame event count and a frame-done pulse.

## Interface

Parameters:
- `N_NEURON`, 98: spike-vector width; fixed, not overridable.
- `IDX_W`, 7: event index width, ceil(log2(98)).

Ports:
- `clk`, input, 1: the block's single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `vec_valid_i`, input, 1: spike vector offered.
- `vec_ready_o`, output, 1: block can accept a vector.
- `vec_i`, input, 98: spike vector; bit n = neuron n fired.
- `evt_valid_o`, output, 1: event index valid.
- `evt_ready_i`, input, 1: consumer accepts event.
- `evt_idx_o`, output, 7: neuron index of the current event.
- `evt_last_o`, output, 1: current event is the last of the frame.
- `done_o`, output, 1: one-cycle pulse; frame finished.
- `frame_cnt_o`, output, 7: number of events in the finished frame; valid from `done_o` until the next `done_o`.

## Operation

- State: 98-bit `pending` register, 7-bit event counter, FSM {IDLE, SCAN}.
- IDLE:
  - `vec_ready_o`=1.
  - On `vec_valid_i`: `pending`<=`vec_i` and counter<=0.
  - If `vec_i`≠0, go to SCAN.
  - If `vec_i`==0, stay in IDLE and schedule `done_o` with count 0. An empty frame emits no events.
- SCAN:
  - `evt_valid_o`=1.
  - `evt_idx_o` = lowest set index of `pending`.
  - `evt_last_o`=1 when exactly one bit of `pending` is set.
- Event handshake (`evt_valid_o`&`evt_ready_i`):
  - Clear that bit in `pending` and increment the counter.
  - If `evt_last_o`, go to IDLE and schedule `done_o`.
- `done_o` is registered. It is high in the cycle after the final event handshake, or after the empty-vector accept. `frame_cnt_o` updates in that same cycle.
- Output stability: while `evt_valid_o`=1 and `evt_ready_i`=0, `evt_idx_o` and `evt_last_o` hold. `pending` changes only on an event handshake or a vector accept.
- `vec_i` is sampled only on a vector handshake. `vec_ready_o`=0 throughout SCAN (see Configuration).
- Counter maximum is 98; it never wraps.

## Timing

- Reset values:
  - state IDLE, `pending`=0, counter=0.
  - `vec_ready_o`=1, `evt_valid_o`=0, `evt_idx_o`=0, `evt_last_o`=0.
  - `done_o`=0, `frame_cnt_o`=0.
- Reset mid-frame: pending events are discarded. No `done_o` is produced for the aborted frame.
- Latency, vector accepted at cycle 0 with k≥1 set bits and `evt_ready_i` tied high:
  - events at cycles 1..k.
  - `done_o` at cycle k+1.
  - next vector accepted no earlier than cycle k+1.
- Empty vector accepted at cycle 0: `done_o` and `frame_cnt_o`=0 at cycle 1. `vec_ready_o` stays 1.
- `evt_idx_o` and `evt_last_o` are decoded combinationally from registered `pending`. There is no combinational path from `evt_ready_i` to any output.

## Configuration

- Macro: `SPIKE_SER_PREFETCH_EN`.
- Defined:
  - `vec_ready_o` is also 1 in SCAN during the cycle where `evt_valid_o`&`evt_last_o` are both high.
  - A vector accepted in that cycle loads directly, with no bubble. If it is non-zero, the block stays in SCAN and its first event appears the next cycle. If it is zero, the block goes to IDLE and its `done_o` follows the previous frame's `done_o` on the next cycle.
  - The previous frame's `done_o` and `frame_cnt_o` are unaffected.
  - This is a combinational path `evt_ready_i`-independent (`evt_last_o`) → `vec_ready_o`.
- Undefined: `vec_ready_o`=0 in SCAN, which adds a one-cycle gap between frames.

## Test plan

- Reset: hold `reset` 3 cycles mid-SCAN, then release. All outputs take their reset values, no stale events or `done_o` appear, and `vec_ready_o`=1.
- `vec_i` = bits {0,5,97}, `evt_ready_i`=1. Events 0,5,97 at cycles 1,2,3, `evt_last_o` only on 97, `done_o` at cycle 4, `frame_cnt_o`=3.
- Backpressure: bits {3,40}, `evt_ready_i` low for cycles 1–3. `evt_idx_o`=3 held stable with `evt_valid_o`=1 through cycle 3, then 3 and 40 are delivered. `frame_cnt_o`=2.
- All-zero vector: no `evt_valid_o`, `done_o` at cycle 1, `frame_cnt_o`=0.
- All 98 bits set: 98 events indexed 0..97 in order, `evt_last_o` on 97, `frame_cnt_o`=98.
- Back-to-back frames {1} then {2}, `vec_valid_i` held high:
  - With `SPIKE_SER_PREFETCH_EN`: events at cycles 1 and 2.
  - Without: events at cycles 1 and 3.
  - Two `done_o` pulses with count 1 in both builds.

Source files
------------

// File: rtl/spike_event_serializer_98bit_if.sv
// rtl/spike_event_serializer_98bit_if.sv - handshake bundle for the 98-bit spike event serializer
// Purpose: groups the vector-in, event-out and frame-status signals of the serializer.
// Signals:
//   vec_valid_i / vec_ready_o / vec_i[97:0]           : spike vector handshake (upstream -> block)
//   evt_valid_o / evt_ready_i / evt_idx_o[6:0] / evt_last_o : event handshake (block -> consumer)
//   done_o / frame_cnt_o[6:0]                          : frame-finished pulse and its event count
// Modports: slave = serializer side, master = environment side.
interface spike_event_serializer_98bit_if;
  logic        vec_valid_i;
  logic        vec_ready_o;
  logic [97:0] vec_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [6:0]  evt_idx_o;
  logic        evt_last_o;
  logic        done_o;
  logic [6:0]  frame_cnt_o;

  modport slave (
    input  vec_valid_i, vec_i, evt_ready_i,
    output vec_ready_o, evt_valid_o, evt_idx_o, evt_last_o, done_o, frame_cnt_o
  );

  modport master (
    output vec_valid_i, vec_i, evt_ready_i,
    input  vec_ready_o, evt_valid_o, evt_idx_o, evt_last_o, done_o, frame_cnt_o
  );
endinterface

// File: rtl/spike_event_serializer_98bit.sv
// rtl/spike_event_serializer_98bit.sv - 98-bit spike vector to ascending neuron-index event stream
// Purpose: latches a per-timestep spike vector and emits one 7-bit event per set bit, lowest index
//   first, flagging the final event of the frame; pulses done with the frame's event count.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : spike_event_serializer_98bit_if.slave (vector in, events out, done/frame count)
// Optional feature macro: SPIKE_SER_PREFETCH_EN - accept the next vector in the same cycle as the
//   current frame's last event, removing the one-cycle gap between frames.
module spike_event_serializer_98bit (
  input  logic                           clk,
  input  logic                           reset,
  spike_event_serializer_98bit_if.slave  bus
);
  localparam int N_NEURON = 98;
  localparam int IDX_W    = 7;
  localparam logic [N_NEURON-1:0] ONE = N_NEURON'(1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t              r_state;
  logic [N_NEURON-1:0] r_pending;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_frame_cnt;
  logic                r_done;
`ifdef SPIKE_SER_PREFETCH_EN
  // An empty vector taken in the prefetch slot owes a done pulse one cycle after the
  // previous frame's done, so it is deferred through this flag.
  logic                r_done_zero;
`endif

  logic [N_NEURON-1:0] w_rest;
  logic [IDX_W-1:0]    w_idx;
  logic                w_one_left;
  logic                w_evt_valid;
  logic                w_evt_last;
  logic                w_evt_fire;
  logic                w_vec_ready;
  logic                w_vec_fire;

  // Lowest set index: scanning downward lets the lowest hit overwrite higher ones.
  always_comb begin
    w_idx = '0;
    for (int i = N_NEURON - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = IDX_W'(i);
    end
  end

  // x & (x-1) clears the lowest set bit: it is both the post-handshake pending
  // value and, when zero with x non-zero, the "exactly one bit left" test.
  assign w_rest      = r_pending & (r_pending - ONE);
  assign w_one_left  = (r_pending != '0) && (w_rest == '0);
  assign w_evt_valid = (r_state == SCAN);
  assign w_evt_last  = w_evt_valid && w_one_left;
  assign w_evt_fire  = w_evt_valid && bus.evt_ready_i;

`ifdef SPIKE_SER_PREFETCH_EN
  // Ready during the last event regardless of evt_ready_i. If the consumer stalls
  // that last event while a vector is taken, the new vector replaces it.
  assign w_vec_ready = (r_state == IDLE) || w_evt_last;
`else
  assign w_vec_ready = (r_state == IDLE);
`endif
  assign w_vec_fire  = bus.vec_valid_i && w_vec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_cnt       <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
`ifdef SPIKE_SER_PREFETCH_EN
      r_done_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SPIKE_SER_PREFETCH_EN
      r_done_zero <= 1'b0;
      if (r_done_zero) begin
        r_done      <= 1'b1;
        r_frame_cnt <= '0;
      end
`endif
      if (w_evt_fire) begin
        r_pending <= w_rest;
        r_cnt     <= r_cnt + 7'd1;
        if (w_evt_last) begin
          r_state     <= IDLE;
          r_done      <= 1'b1;
          r_frame_cnt <= r_cnt + 7'd1;
        end
      end
      // Placed after the event update so a prefetched vector wins pending/counter/state.
      if (w_vec_fire) begin
        r_pending <= bus.vec_i;
        r_cnt     <= '0;
        if (bus.vec_i != '0) begin
          r_state <= SCAN;
        end else begin
          r_state <= IDLE;
`ifdef SPIKE_SER_PREFETCH_EN
          if (r_state == SCAN) begin
            r_done_zero <= 1'b1;
          end else begin
            r_done      <= 1'b1;
            r_frame_cnt <= '0;
          end
`else
          r_done      <= 1'b1;
          r_frame_cnt <= '0;
`endif
        end
      end
    end
  end

  assign bus.vec_ready_o = w_vec_ready;
  assign bus.evt_valid_o = w_evt_valid;
  assign bus.evt_idx_o   = w_idx;
  assign bus.evt_last_o  = w_evt_last;
  assign bus.done_o      = r_done;
  assign bus.frame_cnt_o = r_frame_cnt;
endmodule

// File: tb/tb_spike_event_serializer_98bit.sv
// tb/tb_spike_event_serializer_98bit.sv - self-checking bench for spike_event_serializer_98bit
module tb_spike_event_serializer_98bit;
  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  spike_event_serializer_98bit_if bus();

  spike_event_serializer_98bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [97:0] vec;
    int          exp_cnt;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [97:0] rand_vec(input int pct);
    logic [97:0] v;
    for (int n = 0; n < 98; n++) v[n] = (int'($urandom_range(0, 99)) < pct);
    return v;
  endfunction

  // Offers one vector, drains the frame and checks it against the list of set bits.
  task automatic run_frame(input logic [97:0] v, input bit rnd_ready, input string tag,
                           output int got_cnt, output int got_first, output int got_last_idx);
    int exp_q[$];
    int got_q[$];
    int cyc, done_n, done_cyc, fc, k, prev_idx;
    bit prev_stall;
    got_first    = -1;
    got_last_idx = -1;
    for (int n = 0; n < 98; n++) if (v[n]) exp_q.push_back(n);
    k = exp_q.size();
    bus.vec_i = v;
    bus.vec_valid_i = 1'b1;
    bus.evt_ready_i = 1'b1;
    cyc = 0;
    while (!bus.vec_ready_o && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, " vec_ready before accept"}, int'(bus.vec_ready_o), 1);
    tick();
    bus.vec_valid_i = 1'b0;
    bus.vec_i = rand_vec(50);
    cyc = 1; done_n = 0; done_cyc = -1; fc = -1; prev_stall = 1'b0; prev_idx = 0;
    while (cyc < 800 && done_n == 0) begin
      bus.evt_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (prev_stall) begin
        check({tag, " idx held under stall"}, int'(bus.evt_idx_o), prev_idx);
        check({tag, " valid held under stall"}, int'(bus.evt_valid_o), 1);
      end
      if (bus.done_o) begin
        done_n++;
        done_cyc = cyc;
        fc = int'(bus.frame_cnt_o);
      end
      if (bus.evt_valid_o && bus.evt_ready_i) begin
        got_q.push_back(int'(bus.evt_idx_o));
        check({tag, " last flag"}, int'(bus.evt_last_o), int'(got_q.size() == k));
        if (!rnd_ready) check({tag, " event cycle"}, cyc, got_q.size());
      end
      prev_stall = bus.evt_valid_o && !bus.evt_ready_i;
      prev_idx = int'(bus.evt_idx_o);
      tick();
      cyc++;
    end
    check({tag, " done seen once"}, done_n, 1);
    check({tag, " done one cycle"}, int'(bus.done_o), 0);
    check({tag, " frame_cnt"}, fc, k);
    if (!rnd_ready) check({tag, " done cycle"}, done_cyc, k + 1);
    check({tag, " event count"}, got_q.size(), k);
    for (int i = 0; i < k && i < got_q.size(); i++)
      check({tag, " event index"}, got_q[i], exp_q[i]);
    got_cnt = got_q.size();
    if (got_cnt > 0) begin
      got_first = got_q[0];
      got_last_idx = got_q[got_cnt - 1];
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int gc, gf, gl, n_bad;
    logic [97:0] v, v2;
    int ev_c[$];
    int ev_i[$];
    int dn_c[$];
    int dn_v[$];
    bit acc;

    for (int i = 0; i < 6; i++) begin
      tbl[i].vec = '0;
    end
    tbl[0].vec[0] = 1'b1; tbl[0].vec[5] = 1'b1; tbl[0].vec[97] = 1'b1;
    tbl[0].exp_cnt = 3;  tbl[0].exp_first = 0;  tbl[0].exp_last = 97;
    tbl[1].exp_cnt = 0;  tbl[1].exp_first = -1; tbl[1].exp_last = -1;
    tbl[2].vec = '1;
    tbl[2].exp_cnt = 98; tbl[2].exp_first = 0;  tbl[2].exp_last = 97;
    tbl[3].vec[50] = 1'b1;
    tbl[3].exp_cnt = 1;  tbl[3].exp_first = 50; tbl[3].exp_last = 50;
    tbl[4].vec[97] = 1'b1;
    tbl[4].exp_cnt = 1;  tbl[4].exp_first = 97; tbl[4].exp_last = 97;
    tbl[5].vec[0] = 1'b1; tbl[5].vec[1] = 1'b1; tbl[5].vec[2] = 1'b1; tbl[5].vec[96] = 1'b1;
    tbl[5].exp_cnt = 4;  tbl[5].exp_first = 0;  tbl[5].exp_last = 96;

    reset = 1'b1;
    bus.vec_valid_i = 1'b0;
    bus.vec_i = '0;
    bus.evt_ready_i = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    check("reset vec_ready", int'(bus.vec_ready_o), 1);
    check("reset evt_valid", int'(bus.evt_valid_o), 0);
    check("reset evt_idx", int'(bus.evt_idx_o), 0);
    check("reset evt_last", int'(bus.evt_last_o), 0);
    check("reset done", int'(bus.done_o), 0);
    check("reset frame_cnt", int'(bus.frame_cnt_o), 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].vec, 1'b0, $sformatf("table%0d", i), gc, gf, gl);
      check($sformatf("table%0d count", i), gc, tbl[i].exp_cnt);
      check($sformatf("table%0d first", i), gf, tbl[i].exp_first);
      check($sformatf("table%0d last", i), gl, tbl[i].exp_last);
    end

    // Backpressure: bits {3,40}, consumer stalled for cycles 1..3.
    v = '0; v[3] = 1'b1; v[40] = 1'b1;
    bus.vec_i = v; bus.vec_valid_i = 1'b1; bus.evt_ready_i = 1'b0;
    tick();
    bus.vec_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("bp stalled valid", int'(bus.evt_valid_o), 1);
      check("bp stalled idx", int'(bus.evt_idx_o), 3);
      check("bp stalled last", int'(bus.evt_last_o), 0);
      tick();
    end
    bus.evt_ready_i = 1'b1;
    check("bp first idx", int'(bus.evt_idx_o), 3);
    tick();
    check("bp second idx", int'(bus.evt_idx_o), 40);
    check("bp second last", int'(bus.evt_last_o), 1);
    tick();
    check("bp done", int'(bus.done_o), 1);
    check("bp frame_cnt", int'(bus.frame_cnt_o), 2);
    check("bp valid after", int'(bus.evt_valid_o), 0);
    tick();

    // Reset mid-SCAN for 3 cycles.
    bus.vec_i = '1; bus.vec_valid_i = 1'b1; bus.evt_ready_i = 1'b0;
    tick();
    bus.vec_valid_i = 1'b0;
    tick();
    check("mid-scan valid", int'(bus.evt_valid_o), 1);
    bus.evt_ready_i = 1'b1;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    check("rst2 vec_ready", int'(bus.vec_ready_o), 1);
    check("rst2 evt_valid", int'(bus.evt_valid_o), 0);
    check("rst2 evt_idx", int'(bus.evt_idx_o), 0);
    check("rst2 evt_last", int'(bus.evt_last_o), 0);
    check("rst2 done", int'(bus.done_o), 0);
    check("rst2 frame_cnt", int'(bus.frame_cnt_o), 0);
    n_bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.evt_valid_o || bus.done_o || !bus.vec_ready_o) n_bad++;
      tick();
    end
    check("rst2 no stale activity", n_bad, 0);

    // Back-to-back {1} then {2} with vec_valid held high.
    v = '0; v[1] = 1'b1;
    v2 = '0; v2[2] = 1'b1;
    bus.evt_ready_i = 1'b1;
    bus.vec_i = v; bus.vec_valid_i = 1'b1;
    tick();
    bus.vec_i = v2;
    for (int c = 1; c <= 6; c++) begin
      if (bus.evt_valid_o) begin
        ev_c.push_back(c);
        ev_i.push_back(int'(bus.evt_idx_o));
      end
      if (bus.done_o) begin
        dn_c.push_back(c);
        dn_v.push_back(int'(bus.frame_cnt_o));
      end
      acc = bus.vec_valid_i && bus.vec_ready_o;
      tick();
      if (acc) bus.vec_valid_i = 1'b0;
    end
    check("b2b event count", ev_c.size(), 2);
    check("b2b done count", dn_c.size(), 2);
    if (ev_c.size() == 2) begin
      check("b2b ev0 cycle", ev_c[0], 1);
      check("b2b ev0 idx", ev_i[0], 1);
      check("b2b ev1 idx", ev_i[1], 2);
`ifdef SPIKE_SER_PREFETCH_EN
      check("b2b ev1 cycle", ev_c[1], 2);
`else
      check("b2b ev1 cycle", ev_c[1], 3);
`endif
    end
    if (dn_c.size() == 2) begin
      check("b2b done0 cnt", dn_v[0], 1);
      check("b2b done1 cnt", dn_v[1], 1);
      check("b2b done0 cycle", dn_c[0], 2);
`ifdef SPIKE_SER_PREFETCH_EN
      check("b2b done1 cycle", dn_c[1], 3);
`else
      check("b2b done1 cycle", dn_c[1], 4);
`endif
    end

    // Randomized frames with random consumer stalls.
    for (int f = 0; f < 25; f++) begin
      int dens;
      case ($urandom_range(0, 4))
        0: dens = 0;
        1: dens = 2;
        2: dens = 10;
        3: dens = 50;
        default: dens = 100;
      endcase
      run_frame(rand_vec(dens), 1'b1, $sformatf("rand%0d", f), gc, gf, gl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
